// File: rtl/norm_shift_pipe_pkg.sv
// rtl/norm_shift_pipe_pkg.sv - shared widths, count-width helper and result struct for the normalizer
package norm_shift_pipe_pkg;

    localparam int DEF_W  = 32;
    localparam int DEF_EW = 8;

    function automatic int lzc_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

    localparam int DEF_LW = lzc_width(DEF_W);

    typedef struct packed {
        logic [DEF_W-1:0]  data;
        logic [DEF_EW-1:0] exp;
        logic [DEF_LW-1:0] lzc;
        logic              zero;
        logic              uflow;
    } norm_res_t;

endpackage

// File: rtl/norm_shift_pipe_if.sv
// rtl/norm_shift_pipe_if.sv - input/output valid-ready bundle of the normalizer
interface norm_shift_pipe_if #(
    parameter int W  = 32,
    parameter int EW = 8,
    parameter int LW = $clog2(W)
) ();
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [EW-1:0] in_exp;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [EW-1:0] out_exp;
    logic [LW-1:0] out_lzc;
    logic          out_zero;
    logic          out_uflow;

    modport slave (
        input  in_valid, in_data, in_exp, out_ready,
        output in_ready, out_valid, out_data, out_exp, out_lzc, out_zero, out_uflow
    );

    modport master (
        output in_valid, in_data, in_exp, out_ready,
        input  in_ready, out_valid, out_data, out_exp, out_lzc, out_zero, out_uflow
    );
endinterface

// File: rtl/norm_shift_pipe_lzd_tree.sv
// rtl/norm_shift_pipe_lzd_tree.sv - recursive leading-zero detector (module lzd_tree)
module lzd_tree #(
    parameter int W  = 32,
    parameter int LW = $clog2(W)
) (
    input  logic [W-1:0]  d,
    output logic [LW-1:0] cnt,
    output logic          zero
);
    generate
        if (W == 2) begin : g_leaf
            assign cnt  = ~d[1];
            assign zero = ~(d[1] | d[0]);
        end else begin : g_node
            logic [LW-2:0] cnt_hi, cnt_lo;
            logic          zero_hi, zero_lo;

            lzd_tree #(.W(W/2)) u_hi (.d(d[W-1:W/2]), .cnt(cnt_hi), .zero(zero_hi));
            lzd_tree #(.W(W/2)) u_lo (.d(d[W/2-1:0]), .cnt(cnt_lo), .zero(zero_lo));

            // An empty upper half contributes W/2 zeros; the count is don't-care when both are empty
            assign zero = zero_hi & zero_lo;
            assign cnt  = zero_hi ? {1'b1, cnt_lo} : {1'b0, cnt_hi};
        end
    endgenerate
endmodule

// File: rtl/norm_shift_pipe.sv
// rtl/norm_shift_pipe.sv - two-stage normalizer: LZD capture, then shift and exponent adjust
// Optional gradual underflow when NORM_DENORM_EN is defined.
module norm_shift_pipe
    import norm_shift_pipe_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int EW = DEF_EW
) (
    input  logic             clk,
    input  logic             rst_n,
    norm_shift_pipe_if.slave bus
);
    localparam int LW = lzc_width(W);

    logic          s1_valid, s2_valid;
    logic          s1_adv, s2_adv;
    logic [W-1:0]  s1_data;
    logic [EW-1:0] s1_exp;
    logic [LW-1:0] s1_lzc;
    logic          s1_zero;

    logic [LW-1:0] lzd_cnt;
    logic          lzd_zero;

    logic [W-1:0]  r_data;
    logic [EW-1:0] r_exp;
    logic [LW-1:0] r_lzc;
    logic          r_zero, r_uflow;

    logic [LW-1:0] shamt;
    logic [EW:0]   diff;
    logic          uflow;
    logic [EW-1:0] adj_exp;

    assign s2_adv       = !s2_valid || bus.out_ready;
    assign s1_adv       = !s1_valid || s2_adv;
    assign bus.in_ready = s1_adv;

    lzd_tree #(.W(W)) u_lzd (.d(bus.in_data), .cnt(lzd_cnt), .zero(lzd_zero));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_exp   <= '0;
            s1_lzc   <= '0;
            s1_zero  <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_data <= bus.in_data;
                s1_exp  <= bus.in_exp;
                s1_lzc  <= lzd_zero ? '0 : lzd_cnt;
                s1_zero <= lzd_zero;
            end
        end
    end

    // The borrow out of the EW+1 bit subtraction flags an exponent that would go negative
    always_comb begin
        shamt   = s1_lzc;
        diff    = '0;
        uflow   = 1'b0;
        adj_exp = '0;
`ifdef NORM_DENORM_EN
        uflow   = (EW+1)'(s1_lzc) > {1'b0, s1_exp};
        shamt   = uflow ? LW'(s1_exp) : s1_lzc;
        diff    = {1'b0, s1_exp} - (EW+1)'(shamt);
        adj_exp = diff[EW-1:0];
`else
        diff    = {1'b0, s1_exp} - (EW+1)'(shamt);
        uflow   = diff[EW];
        adj_exp = uflow ? '0 : diff[EW-1:0];
`endif
        if (s1_zero) begin
            adj_exp = '0;
            uflow   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            r_data   <= '0;
            r_exp    <= '0;
            r_lzc    <= '0;
            r_zero   <= 1'b0;
            r_uflow  <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                r_data  <= s1_data << shamt;
                r_exp   <= adj_exp;
                r_lzc   <= shamt;
                r_zero  <= s1_zero;
                r_uflow <= uflow;
            end
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.out_data  = r_data;
    assign bus.out_exp   = r_exp;
    assign bus.out_lzc   = r_lzc;
    assign bus.out_zero  = r_zero;
    assign bus.out_uflow = r_uflow;
endmodule

// File: tb/tb_norm_shift_pipe.sv
// tb/tb_norm_shift_pipe.sv - scoreboard bench for norm_shift_pipe with a reference normalizer
module tb_norm_shift_pipe;
    import norm_shift_pipe_pkg::*;

    localparam int W  = 32;
    localparam int EW = 8;
    localparam int LW = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    norm_shift_pipe_if #(.W(W), .EW(EW), .LW(LW)) bus ();
    norm_shift_pipe #(.W(W), .EW(EW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    norm_res_t exp_q[$];
    int checks   = 0;
    int errors   = 0;
    int rdy_mode = 0;
    int accepts  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    function automatic norm_res_t model(input logic [W-1:0] d, input logic [EW-1:0] e);
        norm_res_t r;
        int lz, sh;
        r  = '0;
        lz = 0;
        if (d == 0) begin
            r.zero = 1'b1;
            return r;
        end
        while (d[W-1-lz] == 1'b0) lz++;
`ifdef NORM_DENORM_EN
        sh      = (lz > int'(e)) ? int'(e) : lz;
        r.uflow = lz > int'(e);
        r.exp   = EW'(int'(e) - sh);
`else
        sh      = lz;
        r.uflow = lz > int'(e);
        r.exp   = r.uflow ? '0 : EW'(int'(e) - lz);
`endif
        r.data = d << sh;
        r.lzc  = LW'(sh);
        return r;
    endfunction

    task automatic send(input logic [W-1:0] d, input logic [EW-1:0] e, input norm_res_t r);
        int n;
        n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_exp   = e;
        forever begin
            #4;
            if (bus.in_ready) begin
                exp_q.push_back(r);
                accepts++;
                @(posedge clk);
                break;
            end
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: got in_ready low for %0d cycles expected acceptance", n);
                @(posedge clk);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Downstream readiness: 0 = always ready, 1 = random, 2 = stalled
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(negedge clk);
            #1;
            case (rdy_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    initial begin
        norm_res_t cur, held, e;
        logic hold_v;
        hold_v = 1'b0;
        held   = '0;
        forever begin
            @(negedge clk);
            #4;
            if (!rst_n) begin
                hold_v = 1'b0;
                continue;
            end
            cur = '{data: bus.out_data, exp: bus.out_exp, lzc: bus.out_lzc,
                    zero: bus.out_zero, uflow: bus.out_uflow};
            if (hold_v) begin
                check("hold_valid", 64'(bus.out_valid), 64'(1'b1));
                check("hold_result", 64'(cur), 64'(held));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got data 0x%0h expected no beat", cur.data);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", 64'(cur.data), 64'(e.data));
                    check("out_exp", 64'(cur.exp), 64'(e.exp));
                    check("out_lzc", 64'(cur.lzc), 64'(e.lzc));
                    check("out_zero", 64'(cur.zero), 64'(e.zero));
                    check("out_uflow", 64'(cur.uflow), 64'(e.uflow));
                end
                hold_v = 1'b0;
            end else if (bus.out_valid) begin
                hold_v = 1'b1;
                held   = cur;
            end else begin
                hold_v = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1);
    end

    initial begin
        logic [W-1:0]  d;
        logic [EW-1:0] ex;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_exp   = '0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'(1'b0));
        check("rst_in_ready", 64'(bus.in_ready), 64'(1'b1));
        check("rst_out_data", 64'(bus.out_data), 64'(0));
        check("rst_out_exp", 64'(bus.out_exp), 64'(0));
        check("rst_out_lzc", 64'(bus.out_lzc), 64'(0));
        check("rst_out_flags", 64'({bus.out_zero, bus.out_uflow}), 64'(0));
        rst_n = 1'b1;

        send(32'h0000_1000, 8'd100, '{data: 32'h8000_0000, exp: 8'd81, lzc: 5'd19, zero: 1'b0, uflow: 1'b0});
        send(32'h8000_0001, 8'd5,   '{data: 32'h8000_0001, exp: 8'd5,  lzc: 5'd0,  zero: 1'b0, uflow: 1'b0});
        send(32'h0000_0000, 8'd50,  '{data: 32'h0,         exp: 8'd0,  lzc: 5'd0,  zero: 1'b1, uflow: 1'b0});
`ifdef NORM_DENORM_EN
        send(32'h0000_0001, 8'd10,  '{data: 32'h0000_0400, exp: 8'd0,  lzc: 5'd10, zero: 1'b0, uflow: 1'b1});
`else
        send(32'h0000_0001, 8'd10,  '{data: 32'h8000_0000, exp: 8'd0,  lzc: 5'd31, zero: 1'b0, uflow: 1'b1});
`endif
        send(32'h0000_0001, 8'd31,  '{data: 32'h8000_0000, exp: 8'd0,  lzc: 5'd31, zero: 1'b0, uflow: 1'b0});
        idle();
        repeat (4) @(negedge clk);
        check("directed_drained", 64'(exp_q.size()), 64'(0));

        rdy_mode = 2;
        accepts  = 0;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    d  = $urandom;
                    ex = 8'($urandom_range(0, 255));
                    send(d, ex, model(d, ex));
                end
                idle();
            end
            begin
                repeat (6) @(negedge clk);
                #3;
                check("bp_in_ready", 64'(bus.in_ready), 64'(1'b0));
                check("bp_accepts", 64'(accepts), 64'(2));
                rdy_mode = 0;
            end
        join
        repeat (6) @(negedge clk);
        check("bp_drained", 64'(exp_q.size()), 64'(0));

        rdy_mode = 1;
        for (int i = 0; i < 300; i++) begin
            d  = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 15) == 0) d = '0;
            ex = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 31)) : 8'($urandom_range(0, 255));
            send(d, ex, model(d, ex));
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();
        rdy_mode = 0;
        repeat (6) @(negedge clk);
        check("rand_drained", 64'(exp_q.size()), 64'(0));

        rdy_mode = 2;
        send(32'h0000_00F0, 8'd40, model(32'h0000_00F0, 8'd40));
        send(32'h0100_0000, 8'd3,  model(32'h0100_0000, 8'd3));
        idle();
        check("full_out_valid", 64'(bus.out_valid), 64'(1'b1));
        check("full_in_ready", 64'(bus.in_ready), 64'(1'b0));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 64'(bus.out_valid), 64'(1'b0));
        exp_q.delete();
        @(negedge clk);
        rst_n    = 1'b1;
        rdy_mode = 0;
        #2;
        check("post_rst_in_ready", 64'(bus.in_ready), 64'(1'b1));
        repeat (6) @(negedge clk);
        check("post_rst_no_stale", 64'(bus.out_valid), 64'(1'b0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
